// File: rtl/tdm_demux_4.sv
// Time-division 1-to-4 demultiplexer: gathers four framed slot words into a
// shadow buffer and publishes them together on Y0..Y3 when slot 3 arrives.
module tdm_demux_4 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             busy,
  output logic [1:0]       slot
);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow_q [3];
  logic [WIDTH-1:0] shadow_d [3];
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic             fv_q, fv_d;
  logic             se_q, se_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
      for (int i = 0; i < 4; i++) y_q[i] <= y_d[i];
    end
  end

  // Idle cycles (din_valid=0) hold everything; the slot-3 word bypasses the
  // shadow buffer and lands directly on Y3 so all four outputs move together.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    for (int i = 0; i < 3; i++) shadow_d[i] = shadow_q[i];
    for (int i = 0; i < 4; i++) y_d[i] = y_q[i];
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sof) begin
            shadow_d[0] = din;
            slot_d      = 2'd1;
            state_d     = RECV;
          end
        end
        RECV: begin
          if (sof) begin
            se_d        = 1'b1;
            shadow_d[0] = din;
            slot_d      = 2'd1;
          end else if (slot_q == 2'd3) begin
            for (int i = 0; i < 3; i++) y_d[i] = shadow_q[i];
            y_d[3]  = din;
            fv_d    = 1'b1;
            slot_d  = 2'd0;
            state_d = HUNT;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (slot_q == i[1:0]) shadow_d[i] = din;
            end
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q == RECV);
    slot        = slot_q;
    frame_valid = fv_q;
    sync_err    = se_q;
    Y0          = y_q[0];
    Y1          = y_q[1];
    Y2          = y_q[2];
    Y3          = y_q[3];
  end

endmodule
